// File: rtl/sweep_pkg.sv
// Shared types and constants for the pulse sweep controller.
// Holds the FSM state enum, marker DAC codes and default widths.
package sweep_pkg;

  localparam int W_DEF      = 32;
  localparam int FRAC_W_DEF = 16;

  localparam logic [15:0] MARK_HI = 16'h7FFF;
  localparam logic [15:0] MARK_LO = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    APPLY,
    DWELL,
    STEP,
    DONE
  } state_t;

endpackage

// File: rtl/sweep_duty_calc.sv
// Registered duty = (div_val * frac) >> FRAC_W, floored at 1 if frac != 0.
// Ports: clk, rst_n, en (load result), div_val, frac in; duty out.
module sweep_duty_calc
  import sweep_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [W-1:0]      div_val,
  input  logic [FRAC_W-1:0] frac,
  output logic [W-1:0]      duty
);

  logic [W+FRAC_W-1:0] prod;
  logic [W-1:0]        q;
  logic [W-1:0]        nxt;

  always_comb begin
    prod = {{FRAC_W{1'b0}}, div_val}
         * {{W{1'b0}}, frac};
    q    = prod[W+FRAC_W-1:FRAC_W];
    nxt  = q;
    if (frac == '0) begin
      nxt = '0;
    end else if (q == '0) begin
      nxt = W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= '0;
    end else if (en) begin
      duty <= nxt;
    end
  end

endmodule

// File: rtl/pulse_sweep_ctrl.sv
// Steps the mask divider from start to stop, dwelling on period bounds.
// Ports: enable/continuous/start/stop/step/dwell/duty_frac in; divider, duty, step_strobe, done, sweepDAC out.
module pulse_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              continuous,
  input  logic [W-1:0]      start_div,
  input  logic [W-1:0]      stop_div,
  input  logic [W-1:0]      step_div,
  input  logic [W-1:0]      dwell,
  input  logic [FRAC_W-1:0] duty_frac,
  output logic [W-1:0]      divider,
  output logic [W-1:0]      duty,
  output logic              step_strobe,
  output logic              done,
  output logic [15:0]       sweepDAC
);

  state_t state, state_n;

  logic [W-1:0]      cur, cur_n;
  logic [W-1:0]      pcnt, pcnt_n;
  logic [W-1:0]      dcnt, dcnt_n;
  logic [W-1:0]      dw_m1, dw_m1_n;
  logic              dir_up, dir_up_n;
  logic [FRAC_W-1:0] frac_q, frac_n;

  logic [W-1:0]      div_n, duty_n;
  logic              stb_n, done_n;
  logic [15:0]       dac_n;

  logic [W-1:0]      calc_duty;
  logic [W-1:0]      start_c, stop_c;
  logic [W-1:0]      dw_in_m1;
  logic [W:0]        sum;
  logic [W-1:0]      nxt_up, nxt_dn;
  logic              period_end;
  logic              at_stop;

  sweep_duty_calc #(
    .W      (W),
    .FRAC_W (FRAC_W)
  ) u_duty (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state == CALC),
    .div_val (cur),
    .frac    (frac_q),
    .duty    (calc_duty)
  );

  // A zero divider would stall the period counter, so both
  // ends of the sweep are floored at 1.
  always_comb begin
    start_c  = (start_div == '0) ? W'(1) : start_div;
    stop_c   = (stop_div == '0) ? W'(1) : stop_div;
    dw_in_m1 = (dwell == '0) ? '0 : dwell - W'(1);

    sum    = {1'b0, cur} + {1'b0, step_div};
    nxt_up = (sum[W] || sum[W-1:0] > stop_c)
           ? stop_c : sum[W-1:0];
    nxt_dn = (step_div > cur ||
              (cur - step_div) < stop_c)
           ? stop_c : cur - step_div;

    period_end = (pcnt == divider - W'(1));
    at_stop    = (cur == stop_c);
  end

  always_comb begin
    state_n  = state;
    cur_n    = cur;
    pcnt_n   = pcnt;
    dcnt_n   = dcnt;
    dw_m1_n  = dw_m1;
    dir_up_n = dir_up;
    frac_n   = frac_q;
    div_n    = divider;
    duty_n   = duty;
    stb_n    = 1'b0;
    done_n   = done;
    dac_n    = sweepDAC;

    if (!enable) begin
      state_n = IDLE;
      div_n   = '0;
      duty_n  = '0;
      done_n  = 1'b0;
      dac_n   = MARK_LO;
      pcnt_n  = '0;
      dcnt_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          div_n   = '0;
          duty_n  = '0;
          done_n  = 1'b0;
          dac_n   = MARK_LO;
          state_n = LOAD;
        end
        LOAD: begin
          cur_n    = start_c;
          dir_up_n = (stop_c >= start_c);
          frac_n   = duty_frac;
          dw_m1_n  = dw_in_m1;
          state_n  = CALC;
        end
        CALC: begin
          state_n = APPLY;
        end
        APPLY: begin
          div_n   = cur;
          duty_n  = calc_duty;
          stb_n   = 1'b1;
          dac_n   = MARK_HI;
          pcnt_n  = '0;
          dcnt_n  = '0;
          state_n = DWELL;
        end
        DWELL: begin
          if (period_end) begin
            pcnt_n = '0;
            if (dcnt == dw_m1) begin
              dcnt_n  = '0;
              state_n = STEP;
            end else begin
              dcnt_n = dcnt + W'(1);
            end
          end else begin
            pcnt_n = pcnt + W'(1);
          end
        end
        STEP: begin
          frac_n  = duty_frac;
          dw_m1_n = dw_in_m1;
          unique case (1'b1)
            at_stop && continuous: begin
              state_n = LOAD;
            end
            at_stop && !continuous: begin
              state_n = DONE;
              done_n  = 1'b1;
              dac_n   = MARK_LO;
            end
            !at_stop: begin
              cur_n   = dir_up ? nxt_up : nxt_dn;
              state_n = CALC;
            end
          endcase
        end
        DONE: begin
          done_n = 1'b1;
          dac_n  = MARK_LO;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur         <= '0;
      pcnt        <= '0;
      dcnt        <= '0;
      dw_m1       <= '0;
      dir_up      <= 1'b0;
      frac_q      <= '0;
      divider     <= '0;
      duty        <= '0;
      step_strobe <= 1'b0;
      done        <= 1'b0;
      sweepDAC    <= MARK_LO;
    end else begin
      state       <= state_n;
      cur         <= cur_n;
      pcnt        <= pcnt_n;
      dcnt        <= dcnt_n;
      dw_m1       <= dw_m1_n;
      dir_up      <= dir_up_n;
      frac_q      <= frac_n;
      divider     <= div_n;
      duty        <= duty_n;
      step_strobe <= stb_n;
      done        <= done_n;
      sweepDAC    <= dac_n;
    end
  end

endmodule

// File: tb/tb_pulse_sweep_ctrl.sv
// Self-checking bench for pulse_sweep_ctrl.
// Timeline model of the sweep compared against the DUT every cycle.
module tb_pulse_sweep_ctrl;

  localparam int W  = 32;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          continuous = 1'b0;
  logic [W-1:0]  start_div = '0;
  logic [W-1:0]  stop_div = '0;
  logic [W-1:0]  step_div = '0;
  logic [W-1:0]  dwell = '0;
  logic [FW-1:0] duty_frac = '0;
  logic [W-1:0]  divider;
  logic [W-1:0]  duty;
  logic          step_strobe;
  logic          done;
  logic [15:0]   sweepDAC;

  always #5 clk = ~clk;

  pulse_sweep_ctrl #(.W(W), .FRAC_W(FW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .continuous  (continuous),
    .start_div   (start_div),
    .stop_div    (stop_div),
    .step_div    (step_div),
    .dwell       (dwell),
    .duty_frac   (duty_frac),
    .divider     (divider),
    .duty        (duty),
    .step_strobe (step_strobe),
    .done        (done),
    .sweepDAC    (sweepDAC)
  );

  typedef struct {
    logic [31:0] dv;
    logic [31:0] dy;
    logic        stb;
    logic        dn;
    logic [15:0] dac;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   e;
  longint seen_div[$];
  longint seen_duty[$];
  int     checks = 0;
  int     failures = 0;

  task automatic chk(string nm, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d want %0d @%0t",
               nm, act, req, $time);
    end
  endtask

  function automatic longint duty_of(longint d, longint f);
    longint r;
    if (f == 0) return 0;
    r = (d * f) / 65536;
    return (r == 0) ? 1 : r;
  endfunction

  task automatic push_n(int n, longint dv, longint dy,
                        bit stb, bit dn, logic [15:0] dac);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      x.dv  = 32'(dv);
      x.dy  = 32'(dy);
      x.stb = stb;
      x.dn  = dn;
      x.dac = dac;
      exp_q.push_back(x);
    end
  endtask

  // Expected per-cycle outputs from the negedge after enable rises:
  // 4 idle cycles, then per step a strobe, dwell*div held cycles and a
  // gap (2 to the next step, 3 on a continuous wrap), or done forever.
  task automatic model(longint st, longint sp, longint stp,
                       longint dw, longint fr, bit cont, int ncyc);
    longint dwl, first, cur, dy;
    bit     up;
    dwl   = (dw == 0) ? 1 : dw;
    first = (st == 0) ? 1 : st;
    cur   = first;
    up    = (sp >= first);
    push_n(4, 0, 0, 0, 0, 16'h8000);
    while (exp_q.size() < ncyc) begin
      dy = duty_of(cur, fr);
      push_n(1, cur, dy, 1, 0, 16'h7FFF);
      push_n(int'(dwl * cur), cur, dy, 0, 0, 16'h7FFF);
      if (cur == sp) begin
        if (cont) begin
          push_n(3, cur, dy, 0, 0, 16'h7FFF);
          cur = first;
        end else begin
          if (exp_q.size() < ncyc)
            push_n(ncyc - exp_q.size(), cur, dy, 0, 1, 16'h8000);
          break;
        end
      end else begin
        push_n(2, cur, dy, 0, 0, 16'h7FFF);
        if (up) cur = (cur + stp > sp) ? sp : cur + stp;
        else    cur = (cur - stp < sp) ? sp : cur - stp;
      end
    end
    while (exp_q.size() > ncyc) void'(exp_q.pop_back());
  endtask

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("divider", divider, e.dv);
      chk("duty", duty, e.dy);
      chk("step_strobe", step_strobe, e.stb);
      chk("done", done, e.dn);
      chk("sweepDAC", sweepDAC, e.dac);
      if (step_strobe) begin
        seen_div.push_back(divider);
        seen_duty.push_back(duty);
      end
    end
  end

  task automatic wait_drain(int lim);
    int n = 0;
    while (exp_q.size() > 0 && n < lim) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d cycles left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic idle_gap();
    @(posedge clk);
    #2 enable = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic start_run(longint st, longint sp, longint stp,
                           longint dw, longint fr, bit cont, int ncyc);
    @(posedge clk);
    #2;
    start_div  = 32'(st);
    stop_div   = 32'(sp);
    step_div   = 32'(stp);
    dwell      = 32'(dw);
    duty_frac  = 16'(fr);
    continuous = cont;
    enable     = 1'b1;
    seen_div.delete();
    seen_duty.delete();
    model(st, sp, stp, dw, fr, cont, ncyc);
  endtask

  task automatic run(longint st, longint sp, longint stp,
                     longint dw, longint fr, bit cont, int ncyc);
    start_run(st, sp, stp, dw, fr, cont, ncyc);
    wait_drain(ncyc + 10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t want completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst divider", divider, 0);
    chk("rst duty", duty, 0);
    chk("rst dac", sweepDAC, 16'h8000);
    chk("rst strobe", step_strobe, 0);
    chk("rst done", done, 0);
    #5 rst_n = 1'b1;

    // up sweep 10/20/30, duty 50%
    run(10, 30, 10, 2, 32768, 0, 140);
    chk("up strobes", seen_div.size(), 3);
    if (seen_div.size() == 3) begin
      chk("up div0", seen_div[0], 10);
      chk("up div1", seen_div[1], 20);
      chk("up div2", seen_div[2], 30);
      chk("up duty0", seen_duty[0], 5);
      chk("up duty1", seen_duty[1], 10);
      chk("up duty2", seen_duty[2], 15);
    end
    chk("up done", done, 1);

    // down sweep with clamp onto stop
    idle_gap();
    run(25, 10, 10, 1, 32768, 0, 70);
    chk("dn strobes", seen_div.size(), 3);
    if (seen_div.size() == 3) begin
      chk("dn div0", seen_div[0], 25);
      chk("dn div1", seen_div[1], 15);
      chk("dn div2", seen_div[2], 10);
      chk("dn duty0", seen_duty[0], 12);
    end
    chk("dn done", done, 1);

    // continuous wrap
    idle_gap();
    run(4, 6, 1, 1, 32768, 1, 80);
    chk("cont strobes>=5", seen_div.size() >= 5, 1);
    if (seen_div.size() >= 5) begin
      chk("cont div0", seen_div[0], 4);
      chk("cont div1", seen_div[1], 5);
      chk("cont div2", seen_div[2], 6);
      chk("cont div3", seen_div[3], 4);
      chk("cont div4", seen_div[4], 5);
    end
    chk("cont done", done, 0);

    // duty edge cases
    idle_gap();
    run(4, 4, 0, 1, 1, 0, 16);
    chk("duty min", duty, 1);
    idle_gap();
    run(4, 4, 0, 1, 0, 0, 16);
    chk("duty zero", duty, 0);
    idle_gap();
    run(100, 100, 0, 1, 16'hFFFF, 0, 112);
    chk("duty max", duty, 99);

    // abort during CALC: idle outputs, no strobe
    idle_gap();
    start_run(10, 30, 10, 2, 32768, 0, 0);
    push_n(8, 0, 0, 0, 0, 16'h8000);
    @(posedge clk);
    @(posedge clk);
    #2 enable = 1'b0;
    wait_drain(20);
    chk("abort strobes", seen_div.size(), 0);

    // restart from start_div, then reset mid-dwell
    run(10, 30, 10, 2, 32768, 0, 30);
    chk("restart strobes", seen_div.size(), 2);
    if (seen_div.size() == 2) begin
      chk("restart div0", seen_div[0], 10);
      chk("restart div1", seen_div[1], 20);
    end
    #3;
    chk("pre-rst divider", divider, 20);
    rst_n = 1'b0;
    #1;
    chk("async divider", divider, 0);
    chk("async duty", duty, 0);
    chk("async dac", sweepDAC, 16'h8000);
    chk("async strobe", step_strobe, 0);
    chk("async done", done, 0);
    enable = 1'b0;
    #20 rst_n = 1'b1;
    #20;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_sweep_ctrl.md
Name: pulse_sweep_ctrl

Overview:
- Upstream control stage for the pulse-mask generator in the SweptPulse instrument.
- Steps the mask period (`divider`) from a start value to a stop value. Holds each step for a programmable number of complete mask periods.
- Derives `duty` from `divider` using a fixed fractional duty setting.
- Changes `divider` and `duty` only on mask-period boundaries, so the downstream mask never sees a torn period. Also emits a sweep-marker DAC signal and status flags.

Parameters:
- `W`, 32: width of `divider`, `duty`, start, stop, step and dwell values.
- `FRAC_W`, 16: width of the unsigned duty fraction (Q0.FRAC_W).

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  level; 1 = run the sweep, 0 = abort and go idle.
- `continuous`  in  1  1 = restart at `start_div` after reaching stop; 0 = one-shot.
- `start_div`  in  W  first divider value.
- `stop_div`  in  W  final divider value; sweep direction = sign(stop_div − start_div).
- `step_div`  in  W  magnitude of the divider increment per step.
- `dwell`  in  W  mask periods per step; 0 is treated as 1.
- `duty_frac`  in  FRAC_W  duty as a fraction of the period.
- `divider`  out  W  registered period to the mask stage.
- `duty`  out  W  registered pulse width to the mask stage.
- `step_strobe`  out  1  one-cycle pulse on the cycle new `divider`/`duty` take effect.
- `done`  out  1  one-shot sweep complete.
- `sweepDAC`  out  16  signed marker: 0x7FFF while active, 0x8000 otherwise.

Behaviour:
- Async reset: `divider`=0, `duty`=0, `step_strobe`=0, `done`=0, `sweepDAC`=0x8000, internal counters=0, state=IDLE.
  - A 0/0 output puts the downstream mask into its reset condition.
- Inputs are sampled only in LOAD and STEP. Changes mid-step take effect at the next step.
- Duty arithmetic:
  - prod = divider_next × duty_frac, full W+FRAC_W bits.
  - duty = prod >> FRAC_W.
  - If duty_frac≠0 and the result is 0, duty = 1.
  - If duty_frac=0, duty = 0.
  - Product is registered: one pipeline cycle.
- Period counter `pcnt` (W bits):
  - Counts 0..divider−1 while in DWELL; period_end = (pcnt == divider−1).
  - A divider of 0 is never applied while active: start_div=0 is clamped to 1.
- Dwell counter `dcnt`: increments on period_end. At period_end with dcnt == max(dwell,1)−1 → STEP, and dcnt clears.
- States:
  - IDLE: outputs 0/0, `sweepDAC`=0x8000, `done`=0. On `enable`=1 → LOAD.
  - LOAD: cur = max(start_div,1); latch direction → CALC.
  - CALC: compute duty product (1 cycle) → APPLY.
  - APPLY:
    - Register `divider`=cur and `duty`; pulse `step_strobe`; `sweepDAC`=0x7FFF.
    - pcnt=0, dcnt=0 → DWELL.
    - The first mask period starts the cycle after APPLY.
  - DWELL: count periods as above → STEP at end of dwell.
  - STEP:
    - If cur == stop_div: `continuous`=1 → LOAD; otherwise → DONE.
    - Else next = cur ± step_div, clamped so it never passes stop_div (overflow or underflow also clamps to stop_div) → CALC.
    - step_div=0 → cur unchanged: the sweep holds indefinitely (continuous) or holds until aborted.
  - DONE: hold last `divider`/`duty`; `done`=1; `sweepDAC`=0x8000. Leaves only when `enable`=0 → IDLE.
- Transition latency: STEP→CALC→APPLY, so new values appear 3 cycles after the final period_end of a step.
  - Old values persist through these gap cycles.
  - The downstream counter is not reset by this block.
- `enable`=0 in any state: next cycle → IDLE with IDLE outputs. Abort beats a simultaneous period_end or step.
- start_div == stop_div: single step; after its dwell → DONE (one-shot) or re-APPLY of the same value with a strobe (continuous).
- Reset asserted mid-operation: immediate return to reset values regardless of state.

Decomposition:
- Shared package `sweep_pkg`:
  - state enum (IDLE, LOAD, CALC, APPLY, DWELL, STEP, DONE);
  - DAC constants MARK_HI=16'h7FFF and MARK_LO=16'h8000;
  - default W and FRAC_W.
- One natural sub-module, `sweep_duty_calc`: registered multiply-shift-clamp of divider × duty_frac → duty.

Test Plan:
- Reset mid-DWELL: assert `rst_n`=0 → async `divider`=0, `duty`=0, `sweepDAC`=0x8000 the same cycle; no `step_strobe`.
- Up sweep:
  - Stimulus: start=10, stop=30, step=10, dwell=2, duty_frac=0x8000, one-shot.
  - Required: divider sequence 10/20/30 with duty 5/10/15.
  - Each value held exactly 2×divider cycles plus the 3-cycle gap; 3 strobes; `done`=1 after the final dwell.
- Down sweep with clamp: start=25, stop=10, step=10 → 25, 15, 10, then `done`.
- Continuous wrap: start=4, stop=6, step=1, dwell=1 → 4, 5, 6, 4, 5, …; `done` never asserts.
- Duty edge cases:
  - duty_frac=1, divider=4 → duty=1 (minimum clamp).
  - duty_frac=0 → duty=0.
  - duty_frac=0xFFFF, divider=100 → duty=99.
- Abort: drop `enable` during the CALC gap → outputs 0/0 next cycle, no strobe; re-enable → restart from start_div.
